// File: rtl/xbar_cfg_loader_if.sv
// Configuration-stream and select-bus bundle between a config source and
// xbar_cfg_loader. The master drives start/word/valid; the slave (loader)
// drives ready, status and the active select bus. fsm_state exposes the
// loader FSM encoding (0 IDLE, 1 LOAD, 2 CHECK, 3 COMMIT) for observation.
interface xbar_cfg_loader_if #(
  parameter int WORD_W   = 32,
  parameter int CFG_BITS = 324
);
  logic                io_cfg_start;
  logic                io_cfg_word_valid;
  logic                io_cfg_word_ready;
  logic [WORD_W-1:0]   io_cfg_word;
  logic                io_busy;
  logic                io_cfg_done;
  logic                io_cfg_err;
  logic [CFG_BITS-1:0] io_mux_configs;
  logic [1:0]          fsm_state;

  modport master (
    output io_cfg_start, io_cfg_word_valid, io_cfg_word,
    input  io_cfg_word_ready, io_busy, io_cfg_done, io_cfg_err,
    input  io_mux_configs, fsm_state
  );

  modport slave (
    input  io_cfg_start, io_cfg_word_valid, io_cfg_word,
    output io_cfg_word_ready, io_busy, io_cfg_done, io_cfg_err,
    output io_mux_configs, fsm_state
  );
endinterface

// File: rtl/xbar_cfg_loader.sv
// xbar_cfg_loader: streams configuration words into a shadow register,
// range-checks every select field one per cycle, then commits the shadow to
// the active crossbar select bus in a single edge so the crossbar never sees
// a partial or illegal configuration.
// Optional feature macro: XBAR_CFG_READBACK_EN adds io_rb_addr/io_rb_data,
// a registered word-wise readback of the active configuration.
//
// Handshake: a word transfers on a rising edge where io_cfg_word_valid and
// io_cfg_word_ready are both high. ready depends on FSM state only (high in
// LOAD), never on valid; valid is ignored whenever ready is low. The source
// holds word stable while valid is high and ready is low.
module xbar_cfg_loader #(
  parameter int NUM_INS  = 39,
  parameter int NUM_OUTS = 54,
  parameter int SEL_W    = 6,
  parameter int WORD_W   = 32,
  localparam int CFG_BITS  = NUM_OUTS * SEL_W,
  localparam int NUM_WORDS = (CFG_BITS + WORD_W - 1) / WORD_W,
  localparam int CNT_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
  input  logic              clk,
  input  logic              reset,
`ifdef XBAR_CFG_READBACK_EN
  input  logic [CNT_W-1:0]  io_rb_addr,
  output logic [WORD_W-1:0] io_rb_data,
`endif
  xbar_cfg_loader_if.slave  cfg
);

  localparam int FLD_W = (NUM_OUTS > 1) ? $clog2(NUM_OUTS) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_CHECK  = 2'd2,
    S_COMMIT = 2'd3
  } state_t;

  state_t              state;
  logic [CNT_W-1:0]    word_cnt;
  logic [FLD_W-1:0]    field_cnt;
  logic [CFG_BITS-1:0] shadow;
  logic [CFG_BITS-1:0] active;
  logic                busy_q;
  logic                done_q;
  logic                err_q;
  logic [SEL_W-1:0]    cur_field;
  logic                field_bad;

  // Select field currently under range check and its legality.
  always_comb begin
    cur_field = shadow[int'(field_cnt) * SEL_W +: SEL_W];
    field_bad = (int'(cur_field) >= NUM_INS);
  end

  // Loader FSM: load words, check fields, commit atomically; all status registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      word_cnt  <= '0;
      field_cnt <= '0;
      shadow    <= '0;
      active    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cfg.io_cfg_start) begin
            state     <= S_LOAD;
            word_cnt  <= '0;
            field_cnt <= '0;
            err_q     <= 1'b0;
            busy_q    <= 1'b1;
          end
        end
        S_LOAD: begin
          if (cfg.io_cfg_start) begin
            // Abort: restart the load from word 0; active stays as is.
            word_cnt  <= '0;
            field_cnt <= '0;
            err_q     <= 1'b0;
          end else if (cfg.io_cfg_word_valid) begin
            // Word k lands at bits [k*WORD_W +: WORD_W]; bits past CFG_BITS drop.
            for (int b = 0; b < CFG_BITS; b++) begin
              if ((b / WORD_W) == int'(word_cnt)) begin
                shadow[b] <= cfg.io_cfg_word[b % WORD_W];
              end
            end
            word_cnt <= word_cnt + 1'b1;
            if (word_cnt == CNT_W'(NUM_WORDS - 1)) begin
              state     <= S_CHECK;
              field_cnt <= '0;
            end
          end
        end
        S_CHECK: begin
          if (cfg.io_cfg_start) begin
            state     <= S_LOAD;
            word_cnt  <= '0;
            field_cnt <= '0;
            err_q     <= 1'b0;
          end else if (field_bad) begin
            err_q  <= 1'b1;
            state  <= S_IDLE;
            busy_q <= 1'b0;
          end else if (field_cnt == FLD_W'(NUM_OUTS - 1)) begin
            state <= S_COMMIT;
          end else begin
            field_cnt <= field_cnt + 1'b1;
          end
        end
        S_COMMIT: begin
          active <= shadow;
          done_q <= 1'b1;
          if (cfg.io_cfg_start) begin
            // Commit still lands; the new start goes straight into LOAD.
            state     <= S_LOAD;
            word_cnt  <= '0;
            field_cnt <= '0;
            err_q     <= 1'b0;
          end else begin
            state  <= S_IDLE;
            busy_q <= 1'b0;
          end
        end
        default: begin
          state  <= S_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  // Output drive: ready decodes state only; the rest are registers.
  always_comb begin
    cfg.io_cfg_word_ready = (state == S_LOAD);
    cfg.io_busy           = busy_q;
    cfg.io_cfg_done       = done_q;
    cfg.io_cfg_err        = err_q;
    cfg.io_mux_configs    = active;
    cfg.fsm_state         = state;
  end

`ifdef XBAR_CFG_READBACK_EN
  logic [NUM_WORDS*WORD_W-1:0] active_pad;

  // Active config zero-padded to whole words so the top word reads 0 above CFG_BITS.
  always_comb begin
    active_pad                 = '0;
    active_pad[CFG_BITS-1:0]   = active;
  end

  // Registered readback; out-of-range addresses return 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      io_rb_data <= '0;
    end else if (int'(io_rb_addr) < NUM_WORDS) begin
      io_rb_data <= active_pad[int'(io_rb_addr) * WORD_W +: WORD_W];
    end else begin
      io_rb_data <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_xbar_cfg_loader.sv
// Directed bench for xbar_cfg_loader: drivers issue loads, the expected
// done/err event (kind, cycle, busy, select bus) is queued at issue time, and
// a negedge monitor pops and compares whenever the DUT signals an event.
module tb_xbar_cfg_loader;
  localparam int NUM_INS   = 39;
  localparam int NUM_OUTS  = 54;
  localparam int SEL_W     = 6;
  localparam int WORD_W    = 32;
  localparam int CFG_BITS  = NUM_OUTS * SEL_W;
  localparam int NUM_WORDS = (CFG_BITS + WORD_W - 1) / WORD_W;
  localparam int CNT_W     = $clog2(NUM_WORDS);
  localparam int PAD_BITS  = NUM_WORDS * WORD_W;
  localparam int EXP_W     = 2 + 1 + 32 + CFG_BITS;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  xbar_cfg_loader_if #(.WORD_W(WORD_W), .CFG_BITS(CFG_BITS)) cfg ();

`ifdef XBAR_CFG_READBACK_EN
  logic [CNT_W-1:0]  io_rb_addr = '0;
  logic [WORD_W-1:0] io_rb_data;
`endif

  xbar_cfg_loader #(
    .NUM_INS(NUM_INS), .NUM_OUTS(NUM_OUTS), .SEL_W(SEL_W), .WORD_W(WORD_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
`ifdef XBAR_CFG_READBACK_EN
    .io_rb_addr (io_rb_addr),
    .io_rb_data (io_rb_data),
`endif
    .cfg   (cfg)
  );

  // ---------------- scoreboard state ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [EXP_W-1:0]    exp_q[$];
  logic [WORD_W-1:0]   words[NUM_WORDS];
  logic [CFG_BITS-1:0] active_model = '0;

  task automatic check(input string name, input logic [CFG_BITS-1:0] act,
                       input logic [CFG_BITS-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Pack field i = (i*mul+add)%NUM_INS, optionally forcing one field.
  function automatic void fill_words(input int mul, input int add,
                                     input int bad_field, input int bad_val);
    logic [PAD_BITS-1:0] pad;
    pad = '0;
    for (int i = 0; i < NUM_OUTS; i++)
      pad[i*SEL_W +: SEL_W] = SEL_W'((i * mul + add) % NUM_INS);
    if (bad_field >= 0) pad[bad_field*SEL_W +: SEL_W] = SEL_W'(bad_val);
    for (int k = 0; k < NUM_WORDS; k++) words[k] = pad[k*WORD_W +: WORD_W];
  endfunction

  // Select bus the words should produce: LSB-first, bits past CFG_BITS dropped.
  function automatic logic [CFG_BITS-1:0] expected_cfg();
    logic [CFG_BITS-1:0] e;
    for (int b = 0; b < CFG_BITS; b++) e[b] = words[b / WORD_W][b % WORD_W];
    return e;
  endfunction

  task automatic push_exp(input logic [1:0] kind, input logic busy,
                          input int at_cyc, input logic [CFG_BITS-1:0] v);
    exp_q.push_back({kind, busy, 32'(at_cyc), v});
  endtask

  // ---------------- monitor ----------------
  logic err_prev = 1'b0;
  always @(negedge clk) begin
    logic [EXP_W-1:0] e;
    logic [1:0] kind;
    if (reset) begin
      err_prev = 1'b0;
    end else begin
      if (cfg.io_cfg_done || (cfg.io_cfg_err && !err_prev)) begin
        kind = {cfg.io_cfg_err && !err_prev, cfg.io_cfg_done};
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_event: kind %0d at cycle %0d, expected no event", kind, cyc);
        end else begin
          e = exp_q.pop_front();
          check("event_kind", CFG_BITS'(kind), CFG_BITS'(e[EXP_W-1 -: 2]));
          check("event_cycle", CFG_BITS'(cyc), CFG_BITS'(e[CFG_BITS+31 : CFG_BITS]));
          check("busy_at_event", CFG_BITS'(cfg.io_busy), CFG_BITS'(e[EXP_W-3]));
          check("mux_at_event", cfg.io_mux_configs, e[CFG_BITS-1:0]);
        end
      end
      err_prev = cfg.io_cfg_err;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_start();
    cfg.io_cfg_start = 1'b1;
    @(posedge clk); #1;
    cfg.io_cfg_start = 1'b0;
  endtask

  task automatic send_word(input logic [WORD_W-1:0] w, output int acc_cyc);
    int guard;
    guard = 0;
    cfg.io_cfg_word_valid = 1'b1;
    cfg.io_cfg_word = w;
    while (!cfg.io_cfg_word_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard == 50) begin
      n_cmp++;
      n_bad++;
      $display("FAIL ready_timeout: ready 0 for %0d cycles, expected 1", guard);
    end
    @(posedge clk); #1;
    acc_cyc = cyc;
  endtask

  task automatic send_range(input int first, input int last, output int acc);
    for (int k = first; k <= last; k++) send_word(words[k], acc);
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: %0d events pending after %0d cycles, expected 0",
               exp_q.size(), budget);
      exp_q.delete();
    end
    repeat (3) begin @(posedge clk); #1; end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int acc;
    cfg.io_cfg_start      = 1'b0;
    cfg.io_cfg_word_valid = 1'b0;
    cfg.io_cfg_word       = '0;
    repeat (2) @(posedge clk); #1;

    // Reset state
    check("reset_ready", CFG_BITS'(cfg.io_cfg_word_ready), '0);
    check("reset_busy",  CFG_BITS'(cfg.io_busy), '0);
    check("reset_done",  CFG_BITS'(cfg.io_cfg_done), '0);
    check("reset_err",   CFG_BITS'(cfg.io_cfg_err), '0);
    check("reset_mux",   cfg.io_mux_configs, '0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Good load, field i = i%39
    fill_words(1, 0, -1, 0);
    pulse_start();
    check("busy_in_load",  CFG_BITS'(cfg.io_busy), CFG_BITS'(1));
    check("ready_in_load", CFG_BITS'(cfg.io_cfg_word_ready), CFG_BITS'(1));
    send_range(0, NUM_WORDS - 1, acc);
    cfg.io_cfg_word_valid = 1'b0;
    active_model = expected_cfg();
    push_exp(2'd1, 1'b0, acc + NUM_OUTS + 1, active_model);
    wait_drain(200);
    check("field1",    CFG_BITS'(cfg.io_mux_configs[11:6]), CFG_BITS'(1));
    check("field38",   CFG_BITS'(cfg.io_mux_configs[38*SEL_W +: SEL_W]), CFG_BITS'(38));
    check("field39",   CFG_BITS'(cfg.io_mux_configs[39*SEL_W +: SEL_W]), '0);
    check("top_nibble_a", CFG_BITS'(cfg.io_mux_configs[323:320]), CFG_BITS'(4'h3));

    // Asynchronous reset in the middle of a load
    pulse_start();
    send_range(0, 2, acc);
    cfg.io_cfg_word_valid = 1'b0;
    #1 reset = 1'b1;
    #1;
    check("async_rst_ready", CFG_BITS'(cfg.io_cfg_word_ready), '0);
    check("async_rst_busy",  CFG_BITS'(cfg.io_busy), '0);
    check("async_rst_mux",   cfg.io_mux_configs, '0);
    @(posedge clk); #1;
    reset = 1'b0;
    active_model = '0;
    repeat (3) begin @(posedge clk); #1; end
    check("post_rst_mux",  cfg.io_mux_configs, '0);
    check("post_rst_busy", CFG_BITS'(cfg.io_busy), '0);

    // Good load with a second pattern
    fill_words(7, 3, -1, 0);
    pulse_start();
    send_range(0, NUM_WORDS - 1, acc);
    cfg.io_cfg_word_valid = 1'b0;
    active_model = expected_cfg();
    push_exp(2'd1, 1'b0, acc + NUM_OUTS + 1, active_model);
    wait_drain(200);

    // Field 7 out of range: err at accept+8 edges, active untouched
    fill_words(1, 0, 7, 39);
    pulse_start();
    send_range(0, NUM_WORDS - 1, acc);
    cfg.io_cfg_word_valid = 1'b0;
    push_exp(2'd2, 1'b0, acc + 7 + 1, active_model);
    wait_drain(200);
    repeat (10) begin @(posedge clk); #1; end
    check("err_sticky",     CFG_BITS'(cfg.io_cfg_err), CFG_BITS'(1));
    check("err_mux_kept",   cfg.io_mux_configs, active_model);

    // Start clears err; abort after 5 words, then 11 more words are needed
    fill_words(1, 0, -1, 0);
    pulse_start();
    check("err_cleared", CFG_BITS'(cfg.io_cfg_err), '0);
    send_range(0, 4, acc);
    cfg.io_cfg_word_valid = 1'b0;
    pulse_start();
    send_range(0, NUM_WORDS - 2, acc);
    check("still_load_after_10", CFG_BITS'(cfg.fsm_state), CFG_BITS'(1));
    check("ready_after_10",      CFG_BITS'(cfg.io_cfg_word_ready), CFG_BITS'(1));
    send_range(NUM_WORDS - 1, NUM_WORDS - 1, acc);
    cfg.io_cfg_word_valid = 1'b0;
    active_model = expected_cfg();
    push_exp(2'd1, 1'b0, acc + NUM_OUTS + 1, active_model);
    wait_drain(200);

    // valid in IDLE is ignored
    cfg.io_cfg_word_valid = 1'b1;
    cfg.io_cfg_word = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    check("idle_ready", CFG_BITS'(cfg.io_cfg_word_ready), '0);
    cfg.io_cfg_word_valid = 1'b0;

    // Last word 0xFFFFFFF5: only low nibble kept; valid during CHECK ignored
    fill_words(1, 0, -1, 0);
    words[NUM_WORDS-1] = 32'hFFFF_FFF5;
    pulse_start();
    send_range(0, NUM_WORDS - 1, acc);
    cfg.io_cfg_word_valid = 1'b0;
    active_model = expected_cfg();
    push_exp(2'd1, 1'b0, acc + NUM_OUTS + 1, active_model);
    repeat (5) begin @(posedge clk); #1; end
    check("in_check_state", CFG_BITS'(cfg.fsm_state), CFG_BITS'(2));
    cfg.io_cfg_word_valid = 1'b1;
    cfg.io_cfg_word = 32'hFFFF_FFFF;
    repeat (3) begin
      @(posedge clk); #1;
      check("check_ready", CFG_BITS'(cfg.io_cfg_word_ready), '0);
    end
    cfg.io_cfg_word_valid = 1'b0;
    wait_drain(200);
    check("top_nibble_c", CFG_BITS'(cfg.io_mux_configs[323:320]), CFG_BITS'(4'h5));
    check("field53_c",    CFG_BITS'(cfg.io_mux_configs[53*SEL_W +: SEL_W]), CFG_BITS'(22));
    check("field1_c",     CFG_BITS'(cfg.io_mux_configs[11:6]), CFG_BITS'(1));

`ifdef XBAR_CFG_READBACK_EN
    io_rb_addr = CNT_W'(10);
    @(posedge clk); #1;
    check("rb_word10", CFG_BITS'(io_rb_data), CFG_BITS'(32'h0000_0005));
    io_rb_addr = CNT_W'(11);
    @(posedge clk); #1;
    check("rb_word11", CFG_BITS'(io_rb_data), '0);
`endif

    check("queue_empty", CFG_BITS'(exp_q.size()), '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #500000;
    n_bad++;
    $display("FAIL global_timeout: bench still running at %0t, expected finish", $time);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
